hazard_scoreboard: RTL

- Parametrised hazard and forwarding controller for the in-order RV32I pipeline.
- Replaces the fixed-depth, stall-only hazard logic. Tracks in-flight destination registers in an internal shift-register scoreboard, one entry per stage downstream of decode.
- Produces per-operand forwarding selects, load-use stalls, and branch flushes. Includes saturating stall and flush performance counters.

---
 rtl/hazard_scoreboard.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Hazard and forwarding controller for the in-order RV32I pipeline.
//   A shift-register scoreboard holds one entry per stage downstream of decode
//   (entry 0 = EX ... entry NUM_STAGES-1 = WB). Each entry records
//   {vld, rd, we, is_load} of the instruction occupying that stage.
//   From the scoreboard and the decode-stage operands it derives per-operand
//   forwarding selects, load-use / RAW stalls and taken-branch flushes, and
//   keeps saturating stall and flush counters.
//
// Ports
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_hold              global freeze: scoreboard and counters hold, o_stall=1
//   i_id_*              decode-stage instruction (valid, rs1/rs2 + use, rd + we,
//                       is_load)
//   i_br_taken          taken branch resolved at entry BR_STAGE
//   o_stall             hold PC and IF/ID
//   o_flush_front       clear fetch and IF/ID
//   o_flush_stage       per-entry pipeline-register clear
//   o_fwd_sel_rs1/rs2   0 = register file, k+1 = forward from entry k
//   o_stall_cnt         hazard stall cycles (saturating)
//   o_flush_cnt         taken-branch flushes (saturating)
//
//   All outputs are combinational from the scoreboard state and the inputs;
//   the scoreboard itself updates on the next rising edge.
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NUM_STAGES = 4,
  parameter int REG_ADDR_W = 5,
  parameter int FWD_EN     = 1,
  parameter int RF_BYPASS  = 0,
  parameter int LOAD_LAT   = 1,
  parameter int BR_STAGE   = 2,
  parameter int CNT_W      = 32,
  parameter int FSW        = $clog2(NUM_STAGES + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_hold,
  input  logic                  i_id_vld,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_rs1_use,
  input  logic                  i_id_rs2_use,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_rd_we,
  input  logic                  i_id_is_load,
  input  logic                  i_br_taken,
  output logic                  o_stall,
  output logic                  o_flush_front,
  output logic [NUM_STAGES-1:0] o_flush_stage,
  output logic [FSW-1:0]        o_fwd_sel_rs1,
  output logic [FSW-1:0]        o_fwd_sel_rs2,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic [CNT_W-1:0]      o_flush_cnt
);

  // Entries younger than the branch stage are on the wrong path.
  localparam logic [NUM_STAGES-1:0] BR_MASK   = NUM_STAGES'((1 << BR_STAGE) - 1);
  // After the shift those wrong-path entries land in 1..BR_STAGE.
  localparam logic [NUM_STAGES-1:0] KILL_MASK = NUM_STAGES'(((1 << BR_STAGE) - 1) << 1);

  logic [NUM_STAGES-1:0] r_vld;
  logic [NUM_STAGES-1:0] r_we;
  logic [NUM_STAGES-1:0] r_ld;
  logic [REG_ADDR_W-1:0] r_rd [NUM_STAGES];
  logic [CNT_W-1:0]      r_stall_cnt;
  logic [CNT_W-1:0]      r_flush_cnt;

  logic                  w_rs1_live;
  logic                  w_rs2_live;
  logic                  w_haz1;
  logic                  w_haz2;
  logic                  w_haz;
  logic [FSW-1:0]        w_sel1;
  logic [FSW-1:0]        w_sel2;
  logic                  w_new_vld;
  logic [NUM_STAGES-1:0] w_kill;

  // x0 is hard-wired zero, so a read of x0 never depends on anything in flight.
  assign w_rs1_live = i_id_vld & i_id_rs1_use & (i_id_rs1 != '0);
  assign w_rs2_live = i_id_vld & i_id_rs2_use & (i_id_rs2 != '0);

  // Scan oldest to youngest so the youngest matching entry overwrites the
  // result: it holds the newest value of the register.
  always_comb begin
    w_haz1 = 1'b0;
    w_haz2 = 1'b0;
    w_sel1 = '0;
    w_sel2 = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (w_rs1_live && r_vld[k] && r_we[k] && (r_rd[k] == i_id_rs1)) begin
        w_sel1 = FSW'(k + 1);
        // Forwarding: only a load whose data is not yet available blocks.
        // Stall-only: every producer blocks, except WB when the RF bypasses.
        w_haz1 = (FWD_EN != 0) ? (r_ld[k] && (k < LOAD_LAT))
                               : ((k < NUM_STAGES - 1) || (RF_BYPASS == 0));
      end
      if (w_rs2_live && r_vld[k] && r_we[k] && (r_rd[k] == i_id_rs2)) begin
        w_sel2 = FSW'(k + 1);
        w_haz2 = (FWD_EN != 0) ? (r_ld[k] && (k < LOAD_LAT))
                               : ((k < NUM_STAGES - 1) || (RF_BYPASS == 0));
      end
    end
  end

  assign w_haz = w_haz1 | w_haz2;

  // Priority: reset > hold > taken branch > hazard stall.
  always_comb begin
    o_stall       = 1'b0;
    o_flush_front = 1'b0;
    o_flush_stage = '0;
    o_fwd_sel_rs1 = '0;
    o_fwd_sel_rs2 = '0;
    if (!i_reset) begin
      // Selects stay live under hold; they are zeroed only on a hazard stall.
      if ((FWD_EN != 0) && !w_haz) begin
        o_fwd_sel_rs1 = w_sel1;
        o_fwd_sel_rs2 = w_sel2;
      end
      if (i_hold) begin
        o_stall = 1'b1;
      end else if (i_br_taken) begin
        o_flush_front = 1'b1;
        o_flush_stage = BR_MASK;
      end else begin
        o_stall = w_haz;
      end
    end
  end

  // A stall or a flush puts a bubble into entry 0.
  assign w_new_vld = i_id_vld & ~w_haz & ~i_br_taken;
  assign w_kill    = i_br_taken ? KILL_MASK : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vld       <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!i_hold) begin
      r_vld <= {r_vld[NUM_STAGES-2:0], w_new_vld} & ~w_kill;
      r_we  <= {r_we[NUM_STAGES-2:0], i_id_rd_we};
      r_ld  <= {r_ld[NUM_STAGES-2:0], i_id_is_load};
      r_rd[0] <= i_id_rd;
      for (int k = 1; k < NUM_STAGES; k++) begin
        r_rd[k] <= r_rd[k-1];
      end
      if (i_br_taken) begin
        if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end else if (w_haz) begin
        if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule
